pipeline_hazard_ctrl: RTL

Central hazard controller for the 5-stage RV32I pipeline. It generates the stall, flush, bubble and freeze controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers three hazards: load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses in MEM. A timeout state machine halts the pipeline when a memory access never completes.

---
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles, EX branch flushes, MEM freeze with timeout HALT.
// Outputs are a same-cycle Mealy decode (zero latency); optional perf counters built only with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        IF_ID_Rs1_used,
  input  logic        IF_ID_Rs2_used,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        EX_Branch_Taken,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        DMem_Ready,
  output logic        PCWrite,
  output logic        IF_ID_Stall,
  output logic        IF_ID_Flush,
  output logic        Control_Sig_Stall,
  output logic        Pipe_Freeze,
  output logic        Mem_Timeout,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // wait_cnt reaches this value on the MEM_TIMEOUT-th consecutive freeze cycle
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;

  logic mem_pend;
  logic freeze_req;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_pend   = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign freeze_req = mem_pend & ~DMem_Ready;
  assign rs1_hit    = IF_ID_Rs1_used & (IF_ID_Rs1 == ID_EX_Rd);
  assign rs2_hit    = IF_ID_Rs2_used & (IF_ID_Rs2 == ID_EX_Rd);
  assign load_use   = ID_EX_MemRead & (ID_EX_Rd != 5'd0) & (rs1_hit | rs2_hit);

  // Freeze outranks the branch so a taken branch stays parked in EX until memory completes.
  always_comb begin
    PCWrite           = 1'b1;
    IF_ID_Stall       = 1'b0;
    IF_ID_Flush       = 1'b0;
    Control_Sig_Stall = 1'b0;
    Pipe_Freeze       = 1'b0;
    Mem_Timeout       = 1'b0;
    if (reset) begin
      PCWrite           = 1'b0;
      IF_ID_Flush       = 1'b1;
      Control_Sig_Stall = 1'b1;
    end else if (state == ST_HALT) begin
      PCWrite     = 1'b0;
      IF_ID_Stall = 1'b1;
      Pipe_Freeze = 1'b1;
      Mem_Timeout = 1'b1;
    end else if (freeze_req) begin
      PCWrite     = 1'b0;
      IF_ID_Stall = 1'b1;
      Pipe_Freeze = 1'b1;
    end else if (EX_Branch_Taken) begin
      IF_ID_Flush       = 1'b1;
      Control_Sig_Stall = 1'b1;
    end else if (load_use) begin
      PCWrite           = 1'b0;
      IF_ID_Stall       = 1'b1;
      Control_Sig_Stall = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (freeze_req) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request is treated as completion.
        if (DMem_Ready || !mem_pend) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 16'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        stall_inc;
  logic        flush_inc;

  assign stall_inc = IF_ID_Stall & (state != ST_HALT);
  assign flush_inc = IF_ID_Flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign Stall_Count = stall_cnt;
  assign Flush_Count = flush_cnt;
`else
  assign Stall_Count = 32'd0;
  assign Flush_Count = 32'd0;
`endif

endmodule
